// File: rtl/core_ctrl_pkg.sv
// rtl/core_ctrl_pkg.sv - shared core control constants and return-stack op decode
//
// Holds the opcode, PC-select and pipeline-stage encodings shared by the
// control unit and its side blocks. It also holds the return-address-stack
// operation type and the helper that decodes one request into an operation.
package core_ctrl_pkg;

  // Opcodes that drive the return-address stack
  localparam logic [5:0] CALL = 6'b000011;
  localparam logic [5:0] RET  = 6'b000001;

  // PC mux select value that picks the return-address stack output
  localparam logic [2:0] PCSRC_RET = 3'b000;

  // Pipeline stage encodings
  localparam logic [2:0] STAGE_IF  = 3'b000;
  localparam logic [2:0] STAGE_ID  = 3'b001;
  localparam logic [2:0] STAGE_EX  = 3'b010;
  localparam logic [2:0] STAGE_MEM = 3'b011;
  localparam logic [2:0] STAGE_WB  = 3'b100;

  // One stack operation per strobe edge
  typedef enum logic [1:0] {
    RAS_IDLE    = 2'b00,
    RAS_PUSH    = 2'b01,
    RAS_POP     = 2'b10,
    RAS_REPLACE = 2'b11
  } ras_op_e;

  // Requests are only acted on during the strobe edge cycle. Outside that
  // cycle, push and pop are ignored.
  function automatic ras_op_e decode_ras_op(input logic take,
                                            input logic push,
                                            input logic pop);
    ras_op_e op;
    op = RAS_IDLE;
    if (take) begin
      case ({push, pop})
        2'b10:   op = RAS_PUSH;
        2'b01:   op = RAS_POP;
        2'b11:   op = RAS_REPLACE;
        default: op = RAS_IDLE;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/ras_mem.sv
// rtl/ras_mem.sv - return-address stack storage array
//
// DEPTH x ADDR_W register array. It has one synchronous write port and
// asynchronous reads relative to the stack pointer. The contents are not
// reset, because the valid range is tracked by the owning block.
//
// Ports:
//   clk        core clock
//   we         write enable
//   waddr      write index
//   wdata      write data
//   sp         stack pointer (next free slot, modulo DEPTH)
//   top_data   mem[sp-1], the current top entry when the stack is non-empty
//   below_data mem[sp-2], the entry that becomes the top after a pop
module ras_mem #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 8,
  parameter int SP_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [SP_W-1:0]   waddr,
  input  logic [ADDR_W-1:0] wdata,
  input  logic [SP_W-1:0]   sp,
  output logic [ADDR_W-1:0] top_data,
  output logic [ADDR_W-1:0] below_data
);

  logic [ADDR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // The pointer wraps modulo DEPTH, so a full stack has sp == 0.
  // The top entry is then at DEPTH-1.
  assign top_data   = mem[sp - SP_W'(1)];
  assign below_data = mem[sp - SP_W'(2)];

endmodule

// File: rtl/return_addr_stack.sv
// rtl/return_addr_stack.sv - hardware return-address stack beside the ID stage
//
// A CALL pushes its return PC and a RET pops it back for the PC mux. A request
// is taken only on the rising edge of the control unit's aux_push_pop strobe,
// so each instruction gives exactly one operation. When push and pop are
// requested together, the top entry is returned and replaced.
//
// Ports:
//   clk          core clock
//   reset        synchronous active-low reset
//   push         push request (CALL)
//   pop          pop request (RET)
//   aux_push_pop stage strobe; an operation is taken on its rising edge
//   push_addr    return address to store
//   ret_addr     address from the latest successful pop, held until the next pop
//   ret_valid    one-cycle pulse, the cycle after a successful pop
//   top_addr     current top-of-stack entry, 0 when empty
//   count        number of valid entries, 0..DEPTH
//   empty, full  occupancy flags
//   overflow     sticky: a push was attempted while full
//   underflow    sticky: a pop was attempted while empty
module return_addr_stack
  import core_ctrl_pkg::*;
#(
  parameter  int ADDR_W = 32,
  parameter  int DEPTH  = 8,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              aux_push_pop,
  input  logic [ADDR_W-1:0] push_addr,
  output logic [ADDR_W-1:0] ret_addr,
  output logic              ret_valid,
  output logic [ADDR_W-1:0] top_addr,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam int SP_W = $clog2(DEPTH);

  logic              aux_q;
  logic              take;
  ras_op_e           op;
  logic [SP_W-1:0]   sp;
  logic              is_empty;
  logic              is_full;
  logic              mem_we;
  logic [SP_W-1:0]   mem_waddr;
  logic [ADDR_W-1:0] mem_top;
  logic [ADDR_W-1:0] mem_below;

  // Rising-edge detect. A strobe held high yields a single take.
  assign take = aux_push_pop & ~aux_q;
  assign op   = decode_ras_op(take, push, pop);

  assign is_empty = (count == '0);
  assign is_full  = (count == CNT_W'(DEPTH));
  assign empty    = is_empty;
  assign full     = is_full;

  // Write port control. A replace on a non-empty stack overwrites the
  // current top slot. A replace on an empty stack behaves as a push.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = sp;
    case (op)
      RAS_PUSH: begin
        mem_we    = ~is_full;
        mem_waddr = sp;
      end
      RAS_REPLACE: begin
        mem_we    = 1'b1;
        mem_waddr = is_empty ? sp : (sp - SP_W'(1));
      end
      default: begin
        mem_we    = 1'b0;
        mem_waddr = sp;
      end
    endcase
  end

  ras_mem #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .SP_W   (SP_W)
  ) u_mem (
    .clk        (clk),
    .we         (mem_we),
    .waddr      (mem_waddr),
    .wdata      (push_addr),
    .sp         (sp),
    .top_data   (mem_top),
    .below_data (mem_below)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      aux_q     <= 1'b0;
      sp        <= '0;
      count     <= '0;
      ret_addr  <= '0;
      ret_valid <= 1'b0;
      top_addr  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      aux_q     <= aux_push_pop;
      ret_valid <= 1'b0;
      case (op)
        RAS_PUSH: begin
          if (!is_full) begin
            sp       <= sp + SP_W'(1);
            count    <= count + CNT_W'(1);
            top_addr <= push_addr;
          end else begin
            overflow <= 1'b1;
          end
        end
        RAS_POP: begin
          if (!is_empty) begin
            ret_addr  <= mem_top;
            ret_valid <= 1'b1;
            sp        <= sp - SP_W'(1);
            count     <= count - CNT_W'(1);
            // The entry below the old top becomes the new top, unless the
            // stack is now empty
            top_addr  <= (count == CNT_W'(1)) ? '0 : mem_below;
          end else begin
            underflow <= 1'b1;
          end
        end
        RAS_REPLACE: begin
          if (is_empty) begin
            sp       <= sp + SP_W'(1);
            count    <= count + CNT_W'(1);
            top_addr <= push_addr;
          end else begin
            ret_addr  <= mem_top;
            ret_valid <= 1'b1;
            top_addr  <= push_addr;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_return_addr_stack.sv
// tb/tb_return_addr_stack.sv - self-checking bench for return_addr_stack
module tb_return_addr_stack;

  localparam int ADDR_W = 32;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk;
  logic              reset;
  logic              push;
  logic              pop;
  logic              aux_push_pop;
  logic [ADDR_W-1:0] push_addr;
  logic [ADDR_W-1:0] ret_addr;
  logic              ret_valid;
  logic [ADDR_W-1:0] top_addr;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              underflow;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  // Behavioural model: the stack is a plain queue, and the back of the
  // queue is the top of the stack.
  logic [ADDR_W-1:0] mq[$];
  logic [ADDR_W-1:0] m_ret_addr  = '0;
  logic              m_ret_valid = 1'b0;
  logic              m_ovf       = 1'b0;
  logic              m_unf       = 1'b0;
  logic              m_aux_prev  = 1'b0;

  return_addr_stack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .pop          (pop),
    .aux_push_pop (aux_push_pop),
    .push_addr    (push_addr),
    .ret_addr     (ret_addr),
    .ret_valid    (ret_valid),
    .top_addr     (top_addr),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [ADDR_W-1:0] m_top();
    return (mq.size() == 0) ? '0 : mq[mq.size()-1];
  endfunction

  always @(posedge clk) begin
    bit edge_seen;
    m_ret_valid = 1'b0;
    if (!reset) begin
      mq.delete();
      m_ret_addr = '0;
      m_ovf      = 1'b0;
      m_unf      = 1'b0;
      m_aux_prev = 1'b0;
    end else begin
      edge_seen  = aux_push_pop && !m_aux_prev;
      m_aux_prev = aux_push_pop;
      if (edge_seen) begin
        if (push && !pop) begin
          if (mq.size() < DEPTH) mq.push_back(push_addr);
          else m_ovf = 1'b1;
        end else if (pop && !push) begin
          if (mq.size() > 0) begin
            m_ret_addr  = mq.pop_back();
            m_ret_valid = 1'b1;
          end else begin
            m_unf = 1'b1;
          end
        end else if (pop && push) begin
          if (mq.size() > 0) begin
            m_ret_addr  = mq[mq.size()-1];
            mq[mq.size()-1] = push_addr;
            m_ret_valid = 1'b1;
          end else begin
            mq.push_back(push_addr);
          end
        end
      end
    end
  end

  // Compare every output against the model on every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ret_addr",  ret_addr,  m_ret_addr);
      chk("ret_valid", 32'(ret_valid), 32'(m_ret_valid));
      chk("top_addr",  top_addr,  m_top());
      chk("count",     32'(count), 32'(mq.size()));
      chk("empty",     32'(empty), 32'(mq.size() == 0));
      chk("full",      32'(full),  32'(mq.size() == DEPTH));
      chk("overflow",  32'(overflow),  32'(m_ovf));
      chk("underflow", 32'(underflow), 32'(m_unf));
    end
  end

  task automatic cyc(input logic r, input logic ps, input logic pp,
                     input logic ax, input logic [ADDR_W-1:0] ad);
    @(negedge clk);
    reset        = r;
    push         = ps;
    pop          = pp;
    aux_push_pop = ax;
    push_addr    = ad;
    @(posedge clk);
    #1;
  endtask

  // Lower the strobe for one cycle, then raise it for a single take cycle
  task automatic take_op(input logic ps, input logic pp, input logic [ADDR_W-1:0] ad);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
    cyc(1'b1, ps, pp, 1'b1, ad);
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    reset = 1'b0; push = 1'b0; pop = 1'b0; aux_push_pop = 1'b0; push_addr = '0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk_en = 1;
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'hDEAD);
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full",  32'(full), 0);
    chk("rst_ret_addr", ret_addr, 0);
    chk("rst_top", top_addr, 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_unf", 32'(underflow), 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);

    // Reset in the middle of an operation
    take_op(1'b1, 1'b0, 32'h40);
    chk("mid_cnt_before", 32'(count), 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
    take_op(1'b0, 1'b1, '0);
    chk("mid_ret_valid", 32'(ret_valid), 0);
    chk("mid_count", 32'(count), 0);
    chk("mid_empty", 32'(empty), 1);
    chk("mid_underflow", 32'(underflow), 1);
    do_reset();

    // Push 0x10, 0x20, 0x30, then pop them back
    take_op(1'b1, 1'b0, 32'h10);
    take_op(1'b1, 1'b0, 32'h20);
    take_op(1'b1, 1'b0, 32'h30);
    chk("seq_count", 32'(count), 3);
    chk("seq_top", top_addr, 32'h30);
    chk("model_count", 32'(mq.size()), 3);
    chk("model_top", m_top(), 32'h30);
    for (int i = 3; i >= 1; i--) begin
      take_op(1'b0, 1'b1, '0);
      chk("seq_pop_valid", 32'(ret_valid), 1);
      chk("seq_pop_addr", ret_addr, 32'(i * 16));
      chk("model_pop_addr", m_ret_addr, 32'(i * 16));
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
    chk("seq_valid_drop", 32'(ret_valid), 0);
    chk("seq_empty", 32'(empty), 1);

    // Fill to DEPTH, then push once more
    for (int i = 0; i < DEPTH; i++) take_op(1'b1, 1'b0, 32'h100 + 32'(i));
    chk("fill_full", 32'(full), 1);
    chk("fill_ovf_before", 32'(overflow), 0);
    take_op(1'b1, 1'b0, 32'h1FF);
    chk("fill_ovf", 32'(overflow), 1);
    chk("fill_count", 32'(count), DEPTH);
    chk("fill_top", top_addr, 32'h107);
    take_op(1'b0, 1'b1, '0);
    chk("fill_pop", ret_addr, 32'h107);
    for (int i = 0; i < DEPTH - 1; i++) take_op(1'b0, 1'b1, '0);
    chk("drain_last", ret_addr, 32'h100);

    // Pop while the stack is empty
    take_op(1'b0, 1'b1, '0);
    chk("uf_flag", 32'(underflow), 1);
    chk("uf_ret_hold", ret_addr, 32'h100);
    chk("uf_valid", 32'(ret_valid), 0);
    chk("uf_count", 32'(count), 0);
    do_reset();

    // Strobe held high for 4 cycles gives one push
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'hAA);
    chk("hold_count", 32'(count), 1);
    chk("hold_top", top_addr, 32'hAA);
    do_reset();

    // Replace-top
    take_op(1'b1, 1'b0, 32'h50);
    take_op(1'b1, 1'b1, 32'h60);
    chk("rep_ret", ret_addr, 32'h50);
    chk("rep_valid", 32'(ret_valid), 1);
    chk("rep_count", 32'(count), 1);
    chk("rep_top", top_addr, 32'h60);
    do_reset();

    // Replace on an empty stack behaves as a push
    take_op(1'b1, 1'b1, 32'h77);
    chk("rep_empty_cnt", 32'(count), 1);
    chk("rep_empty_unf", 32'(underflow), 0);
    chk("rep_empty_valid", 32'(ret_valid), 0);
    do_reset();

    // Randomized traffic; the phases bias toward filling or draining
    for (int i = 0; i < 3000; i++) begin
      int phase;
      logic r, ps, pp, ax;
      phase = (i / 150) % 3;
      r  = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      ax = 1'($urandom_range(0, 1));
      case (phase)
        0:       begin ps = ($urandom_range(0, 9) < 8); pp = ($urandom_range(0, 9) < 2); end
        1:       begin ps = ($urandom_range(0, 9) < 2); pp = ($urandom_range(0, 9) < 8); end
        default: begin ps = 1'($urandom_range(0, 1)); pp = 1'($urandom_range(0, 1)); end
      endcase
      cyc(r, ps, pp, ax, $urandom);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
    chk_en = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
